// File: rtl/word_if.sv
// rtl/word_if.sv - register-word valid/ready handshake into the clock chip programmer
interface word_if #(
    parameter int WORD_BITS = 24
) ();
    logic [WORD_BITS-1:0] word_data;
    logic                 word_last;
    logic                 word_valid;
    logic                 word_ready;

    modport master (
        output word_data,
        output word_last,
        output word_valid,
        input  word_ready
    );

    modport slave (
        input  word_data,
        input  word_last,
        input  word_valid,
        output word_ready
    );
endinterface

// File: rtl/clock_chip_prog.sv
// rtl/clock_chip_prog.sv - serial programming sequencer and lock monitor for the board clock synthesizer
module clock_chip_prog #(
    parameter int WORD_BITS    = 24,
    parameter int CLK_DIV      = 4,
    parameter int LOCK_STABLE  = 1024,
    parameter int LOCK_TIMEOUT = 2000000
) (
    input  logic    clk,
    input  logic    reset,
    word_if.slave   word,
    output logic    clock_clk,
    output logic    clock_data,
    output logic    clock_le,
    input  logic    clock_ftest_ld,
    output logic    busy,
    output logic    locked,
    output logic    lock_err,
    output logic    lock_lost
);

    localparam int DW = $clog2(CLK_DIV + 1);
    localparam int BW = $clog2(WORD_BITS + 1);
    localparam int SW = $clog2(LOCK_STABLE + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WORD_BITS - 1);
    localparam logic [SW-1:0] STABLE_N = SW'(LOCK_STABLE);
    localparam logic [TW-1:0] TMO_N    = TW'(LOCK_TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LATCH,
        GAP,
        LOCK_WAIT
    } state_t;

    state_t                state_q, state_d;
    logic [DW-1:0]         div_q, div_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [WORD_BITS-1:0]  shreg_q, shreg_d;
    logic                  last_q, last_d;
    logic [SW-1:0]         stable_q, stable_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic                  locked_q, locked_d;
    logic                  err_q, err_d;
    logic                  lost_q, lost_d;
    logic                  init_q;
    logic                  ld_meta_q, ld_s_q;

    logic                  div_done;
    logic [SW-1:0]         stable_inc;
    logic [TW-1:0]         tmo_inc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            div_q     <= '0;
            bit_q     <= '0;
            shreg_q   <= '0;
            last_q    <= 1'b0;
            stable_q  <= '0;
            tmo_q     <= '0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
            lost_q    <= 1'b0;
            init_q    <= 1'b1;
            ld_meta_q <= 1'b0;
            ld_s_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            last_q    <= last_d;
            stable_q  <= stable_d;
            tmo_q     <= tmo_d;
            locked_q  <= locked_d;
            err_q     <= err_d;
            lost_q    <= lost_d;
            init_q    <= 1'b0;
            ld_meta_q <= clock_ftest_ld;
            ld_s_q    <= ld_meta_q;
        end
    end

    assign div_done   = (div_q == DIV_LAST);
    assign stable_inc = stable_q + SW'(1);
    assign tmo_inc    = tmo_q + TW'(1);

    always_comb begin
        state_d         = state_q;
        div_d           = '0;
        bit_d           = bit_q;
        shreg_d         = shreg_q;
        last_d          = last_q;
        stable_d        = '0;
        tmo_d           = '0;
        locked_d        = locked_q;
        err_d           = err_q;
        lost_d          = lost_q;
        clock_clk       = 1'b0;
        clock_data      = 1'b0;
        clock_le        = 1'b0;
        word.word_ready = 1'b0;

        case (state_q)
            IDLE: begin
                // init_q keeps ready low for the cycle right after reset
                word.word_ready = !init_q;
                if (locked_q && !ld_s_q) begin
                    locked_d = 1'b0;
                    lost_d   = 1'b1;
                end
                if (word.word_valid && !init_q) begin
                    shreg_d  = word.word_data;
                    last_d   = word.word_last;
                    bit_d    = '0;
                    locked_d = 1'b0;
                    err_d    = 1'b0;
                    lost_d   = 1'b0;
                    state_d  = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                clock_data = shreg_q[WORD_BITS-1];
                div_d      = div_done ? '0 : div_q + DW'(1);
                if (div_done) begin
                    state_d = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                clock_clk  = 1'b1;
                clock_data = shreg_q[WORD_BITS-1];
                div_d      = div_done ? '0 : div_q + DW'(1);
                if (div_done) begin
                    shreg_d = {shreg_q[WORD_BITS-2:0], 1'b0};
                    bit_d   = bit_q + BW'(1);
                    state_d = (bit_q == BIT_LAST) ? LATCH : SHIFT_LO;
                end
            end
            LATCH: begin
                clock_le = 1'b1;
                div_d    = div_done ? '0 : div_q + DW'(1);
                if (div_done) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                div_d = div_done ? '0 : div_q + DW'(1);
                if (div_done) begin
                    state_d = last_q ? LOCK_WAIT : IDLE;
                end
            end
            LOCK_WAIT: begin
                stable_d = ld_s_q ? stable_inc : '0;
                tmo_d    = tmo_inc;
                // a stable lock on the timeout cycle still counts as locked
                if (ld_s_q && (stable_inc == STABLE_N)) begin
                    locked_d = 1'b1;
                    state_d  = IDLE;
                end else if (tmo_inc == TMO_N) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign locked    = locked_q;
    assign lock_err  = err_q;
    assign lock_lost = lost_q;

endmodule

// File: tb/tb_clock_chip_prog.sv
// tb/tb_clock_chip_prog.sv - directed table-driven bench for clock_chip_prog
module tb_clock_chip_prog;

    logic clk = 1'b0;
    logic reset;
    logic clock_clk, clock_data, clock_le, clock_ftest_ld;
    logic busy, locked, lock_err, lock_lost;

    word_if #(.WORD_BITS(24)) wif ();

    clock_chip_prog #(
        .WORD_BITS   (24),
        .CLK_DIV     (2),
        .LOCK_STABLE (8),
        .LOCK_TIMEOUT(1000)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .word          (wif.slave),
        .clock_clk     (clock_clk),
        .clock_data    (clock_data),
        .clock_le      (clock_le),
        .clock_ftest_ld(clock_ftest_ld),
        .busy          (busy),
        .locked        (locked),
        .lock_err      (lock_err),
        .lock_lost     (lock_lost)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    int le_pulses = 0;
    int overlap   = 0;
    logic le_prev = 1'b0;

    always @(negedge clk) begin
        if (clock_le && !le_prev) le_pulses++;
        if (clock_le && clock_clk) overlap++;
        le_prev = clock_le;
    end

    logic cap_clk  [0:101];
    logic cap_data [0:101];
    logic cap_le   [0:101];
    logic cap_rdy  [0:101];
    logic cap_busy [0:101];

    typedef struct {
        int         cyc;
        logic [4:0] exp;   // {clock_clk, clock_data, clock_le, word_ready, busy}
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the first negedge after the accepting edge.
    task automatic send_word(input logic [23:0] d, input logic l);
        int waited;
        wif.word_data  = d;
        wif.word_last  = l;
        wif.word_valid = 1'b1;
        waited = 0;
        while (!wif.word_ready && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        chk("accept_timeout", 32'(waited < 3000), 32'd1);
        @(posedge clk);
        @(negedge clk);
        wif.word_valid = 1'b0;
    endtask

    task automatic capture_word(output logic [23:0] bits, output int rises, output int badpos,
                                output int unstable);
        bits = '0; rises = 0; badpos = 0; unstable = 0;
        cap_clk[0] = 1'b0; cap_data[0] = 1'b0; cap_le[0] = 1'b0; cap_rdy[0] = 1'b0; cap_busy[0] = 1'b0;
        for (int j = 1; j <= 101; j++) begin
            if (j > 1) @(negedge clk);
            cap_clk[j]  = clock_clk;
            cap_data[j] = clock_data;
            cap_le[j]   = clock_le;
            cap_rdy[j]  = wif.word_ready;
            cap_busy[j] = busy;
        end
        for (int j = 1; j <= 101; j++) begin
            if (cap_clk[j] && !cap_clk[j-1]) begin
                rises++;
                if (((j - 3) % 4) != 0) badpos++;
                bits = {bits[22:0], cap_data[j]};
            end
            if (cap_clk[j] && cap_clk[j-1] && (cap_data[j] != cap_data[j-1])) unstable++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [23:0] bits;
        int rises, badpos, unstable, le_base, ov_base, acc_cnt, cyc;
        int acc_cyc [4];
        logic [23:0] bp_words [4];

        tbl[0]  = '{1,   5'b01011};
        tbl[1]  = '{2,   5'b01001};
        tbl[2]  = '{3,   5'b11001};
        tbl[3]  = '{4,   5'b11001};
        tbl[4]  = '{5,   5'b00001};
        tbl[5]  = '{7,   5'b10001};
        tbl[6]  = '{11,  5'b11001};
        tbl[7]  = '{15,  5'b10001};
        tbl[8]  = '{23,  5'b11001};
        tbl[9]  = '{95,  5'b10001};
        tbl[10] = '{97,  5'b00101};
        tbl[11] = '{98,  5'b00101};
        tbl[12] = '{99,  5'b00001};
        tbl[13] = '{100, 5'b00001};
        tbl[14] = '{101, 5'b00010};
        tbl[0].exp = 5'b01001;
        bp_words[0] = 24'h111111; bp_words[1] = 24'h222222;
        bp_words[2] = 24'h333333; bp_words[3] = 24'h444444;

        reset = 1'b1;
        clock_ftest_ld = 1'b0;
        wif.word_valid = 1'b0;
        wif.word_last  = 1'b0;
        wif.word_data  = '0;

        // reset state
        repeat (3) @(negedge clk);
        chk("reset_pins", {29'd0, clock_clk, clock_data, clock_le}, 32'd0);
        chk("reset_ready", 32'(wif.word_ready), 32'd0);
        chk("reset_status", {28'd0, busy, locked, lock_err, lock_lost}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 32'(wif.word_ready), 32'd1);

        // basic shift, table-driven
        send_word(24'hA50F3C, 1'b0);
        capture_word(bits, rises, badpos, unstable);
        for (int i = 0; i < 15; i++) begin
            chk($sformatf("basic_vec_cyc%0d", tbl[i].cyc),
                {27'd0, cap_clk[tbl[i].cyc], cap_data[tbl[i].cyc], cap_le[tbl[i].cyc],
                 cap_rdy[tbl[i].cyc], cap_busy[tbl[i].cyc]},
                {27'd0, tbl[i].exp});
        end
        chk("basic_bits", {8'd0, bits}, 32'h00A50F3C);
        chk("basic_rises", rises, 24);
        chk("basic_rise_pos", badpos, 0);
        chk("basic_data_stable", unstable, 0);
        chk("basic_ready_before", 32'(cap_rdy[100]), 32'd0);

        // three-word sequence then lock
        le_base = le_pulses;
        send_word(24'h000001, 1'b0);
        repeat (100) @(negedge clk);
        send_word(24'h800000, 1'b0);
        repeat (100) @(negedge clk);
        send_word(24'hFFFFFF, 1'b1);
        repeat (100) @(negedge clk);
        chk("lockwait_busy", {30'd0, busy, wif.word_ready}, 32'b10);
        clock_ftest_ld = 1'b1;
        repeat (9) @(negedge clk);
        chk("lock_not_early", 32'(locked), 32'd0);
        @(negedge clk);
        chk("lock_set", {28'd0, locked, lock_err, busy, wif.word_ready}, 32'b1001);
        chk("seq_le_pulses", le_pulses - le_base, 3);

        // loss of lock
        clock_ftest_ld = 1'b0;
        @(negedge clk);
        clock_ftest_ld = 1'b1;
        @(negedge clk);
        chk("loss_not_early", {30'd0, locked, lock_lost}, 32'b10);
        @(negedge clk);
        chk("loss_detect", {30'd0, locked, lock_lost}, 32'b01);
        repeat (5) @(negedge clk);
        chk("loss_sticky", {30'd0, locked, lock_lost}, 32'b01);
        send_word(24'h123456, 1'b0);
        chk("loss_cleared", {30'd0, locked, lock_lost}, 32'b00);
        repeat (100) @(negedge clk);

        // lock timeout with a chattering lock-detect
        clock_ftest_ld = 1'b0;
        send_word(24'h654321, 1'b1);
        repeat (100) @(negedge clk);
        for (int j = 101; j <= 1101; j++) begin
            if (((j - 101) % 5) == 0) clock_ftest_ld = ~clock_ftest_ld;
            if (j == 1100) chk("tmo_not_early", {30'd0, lock_err, busy}, 32'b01);
            if (j == 1101) chk("tmo_err", {29'd0, lock_err, locked, wif.word_ready}, 32'b101);
            if (j < 1101) @(negedge clk);
        end
        clock_ftest_ld = 1'b0;

        // reset during SHIFT_HI of bit 10
        send_word(24'h5AF0C3, 1'b0);
        repeat (42) @(negedge clk);
        chk("rst_mid_in_hi", 32'(clock_clk), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_pins", {27'd0, clock_clk, clock_data, clock_le, busy, wif.word_ready}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_ready", 32'(wif.word_ready), 32'd1);
        send_word(24'h5AF0C3, 1'b0);
        capture_word(bits, rises, badpos, unstable);
        chk("rst_mid_bits", {8'd0, bits}, 32'h005AF0C3);
        chk("rst_mid_le", {30'd0, cap_le[97], cap_le[99]}, 32'b10);

        // backpressure: valid held high across four words
        le_base = le_pulses;
        ov_base = overlap;
        acc_cnt = 0;
        cyc = 0;
        wif.word_data  = bp_words[0];
        wif.word_last  = 1'b0;
        wif.word_valid = 1'b1;
        while (acc_cnt < 4 && cyc < 1000) begin
            if (wif.word_ready) begin
                chk($sformatf("bp_idle_%0d", acc_cnt), 32'(busy), 32'd0);
                acc_cyc[acc_cnt] = cyc;
                acc_cnt++;
                @(posedge clk);
                @(negedge clk);
                cyc++;
                if (acc_cnt < 4) wif.word_data = bp_words[acc_cnt];
                else wif.word_valid = 1'b0;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        wif.word_valid = 1'b0;
        chk("bp_accepts", acc_cnt, 4);
        for (int i = 1; i < 4; i++) begin
            if (i < acc_cnt) chk($sformatf("bp_interval_%0d", i), acc_cyc[i] - acc_cyc[i-1], 101);
        end
        repeat (100) @(negedge clk);
        chk("bp_le_pulses", le_pulses - le_base, 4);
        chk("bp_overlap", overlap - ov_base, 0);
        chk("bp_final_ready", 32'(wif.word_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
